// File: rtl/arg_max_n.sv
// arg_max_n: sequential arg-max over N_CLASS signed scores.
// One score is compared per enabled cycle; the result carries the winning index, its score,
// the margin to the runner-up and a rejection flag when that margin falls below a threshold.
module arg_max_n #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned N_CLASS    = 3,
  parameter int unsigned IDX_W      = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          En,
  input  logic                          Run,
  input  logic [N_CLASS*DATA_WIDTH-1:0] XS,
  input  logic [DATA_WIDTH-1:0]         Thr,
  output logic [IDX_W-1:0]              Yc,
  output logic [DATA_WIDTH-1:0]         Ymax,
  output logic [DATA_WIDTH:0]           Margin,
  output logic                          Reject,
  output logic                          Busy,
  output logic                          Ready
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  // Most negative representable score seeds the runner-up.
  localparam logic signed [DATA_WIDTH-1:0] MinScore = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(N_CLASS - 1);
  localparam logic [IDX_W-1:0] FirstCursor = IDX_W'(1);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]        scores_q [N_CLASS];
  logic [DATA_WIDTH-1:0]        thr_q;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic signed [DATA_WIDTH-1:0] cur_score;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IDX_W-1:0]             cursor_q, cursor_d;
  logic                         capture;
  logic [DATA_WIDTH:0]          margin_c;
  logic                         reject_c;

  // Select the captured score under the cursor.
  always_comb begin
    cur_score = scores_q[0];
    for (int unsigned k = 0; k < N_CLASS; k++) begin
      if (cursor_q == IDX_W'(k)) begin
        cur_score = scores_q[k];
      end
    end
  end

  // Next-state logic: capture on Run, one strict signed compare per SCAN cycle.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    case (state_q)
      StIdle: begin
        if (Run) begin
          capture  = 1'b1;
          best_d   = XS[DATA_WIDTH-1:0];
          second_d = MinScore;
          idx_d    = '0;
          cursor_d = FirstCursor;
          state_d  = (N_CLASS == 1) ? StDone : StScan;
        end
      end
      StScan: begin
        // Strict compares keep the lowest index on ties.
        if (cur_score > best_q) begin
          second_d = best_q;
          best_d   = cur_score;
          idx_d    = cursor_q;
        end else if (cur_score > second_q) begin
          second_d = cur_score;
        end
        if (cursor_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cursor_d = cursor_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Difference is always non-negative and fits in one extra bit.
  always_comb begin
    margin_c = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
    reject_c = (margin_c < {1'b0, thr_q});
  end

  assign Busy = (state_q != StIdle);

  // FSM and running best/second registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cursor_q <= '0;
      best_q   <= '0;
      second_q <= '0;
      idx_q    <= '0;
    end else if (En) begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
    end
  end

  // Input capture; later changes on XS/Thr cannot disturb a run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_q <= '0;
      for (int unsigned k = 0; k < N_CLASS; k++) begin
        scores_q[k] <= '0;
      end
    end else if (En && capture) begin
      thr_q <= Thr;
      for (int unsigned k = 0; k < N_CLASS; k++) begin
        scores_q[k] <= XS[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Result registers: cleared by reset, updated only on the DONE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Yc     <= '0;
      Ymax   <= '0;
      Margin <= '0;
      Reject <= 1'b0;
      Ready  <= 1'b0;
    end else if (En) begin
      if (capture) begin
        Ready <= 1'b0;
      end
      if (state_q == StDone) begin
        Yc     <= idx_q;
        Ymax   <= best_q;
        Margin <= margin_c;
        Reject <= reject_c;
        Ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arg_max_n.sv
// Bench for arg_max_n: scoreboard of expected results pushed at Run, popped at Ready.
module tb_arg_max_n;

  localparam int DW = 14;

  typedef struct {
    int yc;
    int ymax;
    int margin;
    int rej;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Three-class instance
  logic            en, run;
  logic [3*DW-1:0] xs;
  logic [DW-1:0]   thr_in;
  logic [1:0]      yc;
  logic [DW-1:0]   ymax;
  logic [DW:0]     margin;
  logic            rej, busy, ready;

  // Single-class instance
  logic            en1, run1;
  logic [DW-1:0]   xs1, thr1;
  logic [0:0]      yc1;
  logic [DW-1:0]   ymax1;
  logic [DW:0]     margin1;
  logic            rej1, busy1, ready1;

  arg_max_n #(.DATA_WIDTH(DW), .N_CLASS(3)) dut (
    .clk(clk), .rst(rst), .En(en), .Run(run), .XS(xs), .Thr(thr_in),
    .Yc(yc), .Ymax(ymax), .Margin(margin), .Reject(rej), .Busy(busy), .Ready(ready)
  );

  arg_max_n #(.DATA_WIDTH(DW), .N_CLASS(1)) dut1 (
    .clk(clk), .rst(rst), .En(en1), .Run(run1), .XS(xs1), .Thr(thr1),
    .Yc(yc1), .Ymax(ymax1), .Margin(margin1), .Reject(rej1), .Busy(busy1), .Ready(ready1)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t sb1[$];
  exp_t prev;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: max value at lowest index, runner-up = max over all other entries.
  function automatic exp_t model3(input int a, input int b, input int c, input int thr);
    exp_t e;
    int   s[3];
    int   bi;
    int   second;
    s  = '{a, b, c};
    bi = 0;
    for (int k = 1; k < 3; k++) if (s[k] > s[bi]) bi = k;
    second = -(1 << (DW - 1));
    for (int k = 0; k < 3; k++) if (k != bi && s[k] > second) second = s[k];
    e.yc     = bi;
    e.ymax   = s[bi];
    e.margin = s[bi] - second;
    e.rej    = (e.margin < thr) ? 1 : 0;
    return e;
  endfunction

  function automatic logic [3*DW-1:0] pack3(input int a, input int b, input int c);
    return {c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  // Drive a Run pulse; returns at the falling edge after the accepting edge.
  task automatic start3(input int a, input int b, input int c, input int thr);
    @(negedge clk);
    xs     = pack3(a, b, c);
    thr_in = thr[DW-1:0];
    run    = 1'b1;
    sb.push_back(model3(a, b, c, thr));
    @(negedge clk);
    run = 1'b0;
    check_eq("busy_after_run", int'(busy), 1);
    check_eq("ready_clr", int'(ready), 0);
    check_eq("hold_yc", int'(yc), prev.yc);
    check_eq("hold_margin", int'(margin), prev.margin);
  endtask

  task automatic wait_result(input string tag, input int start_cyc, input int exp_lat);
    int   cyc;
    int   busy_n;
    exp_t e;
    cyc    = start_cyc;
    busy_n = start_cyc;
    while (!ready && cyc < 50) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (!ready) begin
      check_eq({tag, "_timeout"}, 0, 1);
      return;
    end
    check_eq({tag, "_lat"}, cyc, exp_lat);
    check_eq({tag, "_busy_cycles"}, busy_n, exp_lat);
    check_eq({tag, "_busy_low"}, int'(busy), 0);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, "_yc"}, int'(yc), e.yc);
    check_eq({tag, "_ymax"}, int'($signed(ymax)), e.ymax);
    check_eq({tag, "_margin"}, int'(margin), e.margin);
    check_eq({tag, "_reject"}, int'(rej), e.rej);
    prev = e;
  endtask

  task automatic run1_case(input string tag, input int v, input int thr);
    exp_t e;
    int   cyc;
    @(negedge clk);
    xs1  = v[DW-1:0];
    thr1 = thr[DW-1:0];
    run1 = 1'b1;
    e.yc     = 0;
    e.ymax   = v;
    e.margin = v + (1 << (DW - 1));
    e.rej    = (e.margin < thr) ? 1 : 0;
    sb1.push_back(e);
    @(negedge clk);
    run1 = 1'b0;
    cyc  = 0;
    check_eq({tag, "_busy"}, int'(busy1), 1);
    while (!ready1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, 1);
    e = sb1.pop_front();
    check_eq({tag, "_yc"}, int'(yc1), e.yc);
    check_eq({tag, "_ymax"}, int'($signed(ymax1)), e.ymax);
    check_eq({tag, "_margin"}, int'(margin1), e.margin);
    check_eq({tag, "_reject"}, int'(rej1), e.rej);
  endtask

  initial begin
    en = 1'b1; run = 1'b0; xs = '0; thr_in = '0;
    en1 = 1'b1; run1 = 1'b0; xs1 = '0; thr1 = '0;
    prev = '{0, 0, 0, 0};

    #12;
    check_eq("rst_yc", int'(yc), 0);
    check_eq("rst_ymax", int'(ymax), 0);
    check_eq("rst_margin", int'(margin), 0);
    check_eq("rst_reject", int'(rej), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst1_busy", int'(busy1), 0);
    check_eq("rst1_ready", int'(ready1), 0);
    @(negedge clk);
    rst = 1'b1;

    start3(5, -3, 12, 0);
    wait_result("basic", 0, 3);
    @(negedge clk);
    check_eq("ready_hold", int'(ready), 1);
    check_eq("idle_busy", int'(busy), 0);

    start3(7, 7, -1, 1);
    wait_result("tie", 0, 3);
    start3(8191, -8192, -8192, 16383);
    wait_result("ext_hi", 0, 3);
    start3(-8192, -8192, -8192, 0);
    wait_result("ext_lo", 0, 3);

    for (int i = 0; i < 6; i++) begin
      start3(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
             int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)));
      wait_result("rand", 0, 3);
    end

    // Stall mid-scan with disturbed inputs and a Run while busy.
    start3(5, -3, 12, 0);
    en     = 1'b0;
    xs     = pack3(100, 100, 100);
    thr_in = 14'h3fff;
    @(negedge clk);
    @(negedge clk);
    en  = 1'b1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_result("stall", 3, 5);
    repeat (3) @(negedge clk);
    check_eq("no_rerun_busy", int'(busy), 0);
    check_eq("no_rerun_ready", int'(ready), 1);

    // Asynchronous reset in the middle of a scan.
    start3(9, 50, -20, 5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_yc", int'(yc), 0);
    check_eq("arst_ymax", int'(ymax), 0);
    check_eq("arst_margin", int'(margin), 0);
    check_eq("arst_reject", int'(rej), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_ready", int'(ready), 0);
    sb.delete();
    prev = '{0, 0, 0, 0};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", int'(ready), 0);
    check_eq("post_rst_busy", int'(busy), 0);
    start3(1, 2, 3, 0);
    wait_result("after_rst", 0, 3);

    run1_case("one_min", -8192, 0);
    run1_case("one_rej", 100, 9000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arg_max_n.md
ARG_MAX_N -- requirements
Module: arg_max_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, width of each signed class score.
REQ-002 SHALL have parameter N_CLASS, default 3, number of class scores compared; legal range 1..256.
REQ-003 SHALL have parameter IDX_W, default $clog2(N_CLASS) with a minimum of 1, width of the class index.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port En, input, 1 bit: clock enable; while low, all state and outputs hold.
REQ-007 SHALL have port Run, input, 1 bit: start request, sampled while En is high.
REQ-008 SHALL have port XS, input, N_CLASS*DATA_WIDTH bits: packed signed scores, class k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port Thr, input, DATA_WIDTH bits: unsigned rejection margin threshold, sampled with XS.
REQ-010 SHALL have port Yc, output, IDX_W bits: index of the winning class.
REQ-011 SHALL have port Ymax, output, DATA_WIDTH bits: signed winning score.
REQ-012 SHALL have port Margin, output, DATA_WIDTH+1 bits: unsigned difference, best minus second-best.
REQ-013 SHALL have port Reject, output, 1 bit: high when Margin < Thr.
REQ-014 SHALL have port Busy, output, 1 bit: high while a classification is in progress.
REQ-015 SHALL have port Ready, output, 1 bit: result valid.

Function
REQ-016 SHALL implement the FSM states IDLE, SCAN and DONE; all transitions are qualified by En=1.
REQ-017 In IDLE with Run=1, SHALL capture XS and Thr into internal registers, set best=class0, second=-2^(DATA_WIDTH-1) and cursor=1, clear Ready, and move to SCAN, or to DONE when N_CLASS=1.
REQ-018 In SCAN, SHALL compare one captured score at the cursor per enabled cycle.
REQ-019 The SCAN comparison SHALL follow these rules:
- score > best: second<=best, best<=score, index<=cursor.
- else, score > second: second<=score.
REQ-020 Comparisons SHALL be signed and strict, so on ties the lowest index wins.
REQ-021 SCAN SHALL move to DONE after the comparison at cursor=N_CLASS-1, and the cursor SHALL otherwise increment.
REQ-022 DONE SHALL register the results, set Ready=1 and return to IDLE, with these values:
- Yc=index, Ymax=best.
- Margin=best-second, computed at DATA_WIDTH+1 bits with no overflow.
- Reject=(Margin < Thr) as an unsigned comparison.
REQ-023 Latency SHALL be N_CLASS enabled cycles from Run acceptance to Ready high; for N_CLASS=3, Run accepted at edge 0 gives Ready high after edge 3.
REQ-024 Ready SHALL stay high in IDLE until the next Run is accepted, and it SHALL clear on that accepting edge.
REQ-025 Yc, Ymax, Margin and Reject SHALL change only on the DONE edge and SHALL hold otherwise.
REQ-026 Busy SHALL be high in SCAN and DONE and low in IDLE.
REQ-027 Run while Busy=1 SHALL be ignored, and changes on XS or Thr after capture SHALL NOT affect the result in progress.
REQ-028 With En low mid-SCAN, SHALL freeze the cursor and partial results, and latency SHALL extend by exactly the number of disabled cycles.
REQ-029 For N_CLASS=1, SHALL give Yc=0 and Margin=best+2^(DATA_WIDTH-1).

Reset
REQ-030 rst=0 SHALL immediately, without a clock, force the FSM to IDLE and drive all outputs to 0: Yc, Ymax, Margin, Reject, Busy and Ready.
REQ-031 rst=0 mid-operation SHALL abandon the classification in progress with no partial result output.
REQ-032 The first Run accepted after rst returns high SHALL behave exactly as a Run from a clean reset.

Verification
REQ-033 (DATA_WIDTH=14, N_CLASS=3) XS=(5,-3,12), Thr=0, Run pulse -> Ready after 3 cycles with Yc=2, Ymax=12, Margin=7, Reject=0; Busy high for exactly 3 cycles.
REQ-034 Tie: XS=(7,7,-1), Thr=1 -> Yc=0, Ymax=7, Margin=0, Reject=1.
REQ-035 Extremes: XS=(8191,-8192,-8192), Thr=16383 -> Yc=0, Margin=16383, Reject=0; XS=(-8192,-8192,-8192) -> Yc=0, Margin=0.
REQ-036 En low for 2 cycles during SCAN, with XS changed and Run pulsed while Busy -> Ready after 5 cycles with the originally captured result, and no second run.
REQ-037 rst=0 asserted at cycle 2 of SCAN -> all outputs 0 asynchronously; after release, XS=(1,2,3) with Run -> Yc=2, Margin=1 after 3 cycles.
REQ-038 N_CLASS=1 instance with XS=(-8192) -> Ready after 1 cycle with Yc=0, Ymax=-8192, Margin=0.
